// File: rtl/burst_ram_responder.sv
// Responder end of the burst-RAM user interface: a PSRAM controller model seen by the cache/RAMIO initiator.
// Define BURST_RAM_PROTOCOL_CHECK_EN to build the sticky protocol_error checker; otherwise protocol_error is tied to 0.
module burst_ram_responder #(
    parameter int DEPTH_BITWIDTH = 10,
    parameter int BURST_COUNT    = 4,
    parameter int READ_DELAY     = 2,
    parameter int CALIB_CYCLES   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd,
    input  logic        cmd_en,
    input  logic [20:0] addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  data_mask,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,
    output logic        init_calib,
    output logic        busy,
    output logic        protocol_error
);

    localparam int WORDS   = 1 << DEPTH_BITWIDTH;
    localparam int MAX_CB  = (CALIB_CYCLES > BURST_COUNT) ? CALIB_CYCLES : BURST_COUNT;
    localparam int CNT_MAX = (MAX_CB > READ_DELAY) ? MAX_CB : READ_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0]          cnt_t;
    typedef logic [DEPTH_BITWIDTH-1:0] word_addr_t;

    // Each state exits when the shared counter reaches its last cycle; beat 0 of a
    // write is taken in the accept cycle, so WRITE lasts one cycle less than READ.
    localparam cnt_t       CALIB_LAST = cnt_t'(CALIB_CYCLES - 1);
    localparam cnt_t       WRITE_LAST = cnt_t'(BURST_COUNT - 2);
    localparam cnt_t       WAIT_LAST  = cnt_t'(READ_DELAY - 1);
    localparam cnt_t       READ_LAST  = cnt_t'(BURST_COUNT - 1);
    localparam cnt_t       CNT_ONE    = cnt_t'(1);
    localparam word_addr_t ADDR_ONE   = word_addr_t'(1);

    typedef enum logic [2:0] {
        CALIB,
        IDLE,
        WRITE,
        READ_WAIT,
        READ
    } state_t;

    state_t     state;
    state_t     state_next;
    cnt_t       cnt;
    word_addr_t ptr;
    word_addr_t start;
    word_addr_t beat_addr;
    logic       accept;
    logic       wr_en;
    logic       rd_load;
    logic       unused_addr;

    logic [63:0] mem [WORDS];

    assign start       = addr[DEPTH_BITWIDTH-1:0];
    assign accept      = (state == IDLE) && cmd_en;
    assign beat_addr   = (state == IDLE) ? start : ptr;
    assign wr_en       = !rst && ((accept && cmd) || (state == WRITE));
    assign rd_load     = (state_next == READ);
    assign init_calib  = (state != CALIB);
    assign busy        = (state == WRITE) || (state == READ_WAIT) || (state == READ);
    assign unused_addr = ^addr[20:DEPTH_BITWIDTH];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            CALIB:     if (cnt == CALIB_LAST) state_next = IDLE;
            IDLE: begin
                if (cmd_en) begin
                    if (cmd) begin
                        if (BURST_COUNT > 1) state_next = WRITE;
                    end else if (READ_DELAY > 0) begin
                        state_next = READ_WAIT;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE:     if (cnt == WRITE_LAST) state_next = IDLE;
            READ_WAIT: if (cnt == WAIT_LAST)  state_next = READ;
            READ:      if (cnt == READ_LAST)  state_next = IDLE;
            default:   state_next = CALIB;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CALIB;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CNT_ONE;
            if (wr_en || rd_load) begin
                ptr <= beat_addr + ADDR_ONE;
            end else if (accept) begin
                ptr <= start;
            end
        end
    end

    // NOTE: the array has no reset: contents must survive rst, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (!data_mask[i]) mem[beat_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read beats are registered one cycle ahead of the READ state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else if (rd_load) begin
            rd_data_valid <= 1'b1;
            rd_data       <= mem[beat_addr];
        end else begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end
    end

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_error <= 1'b0;
        end else if (cmd_en && (state != IDLE)) begin
            protocol_error <= 1'b1;
        end
    end
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed self-checking bench for burst_ram_responder (default parameters).
// Honours BURST_RAM_PROTOCOL_CHECK_EN for the protocol_error expectations.
module tb_burst_ram_responder;

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd;
    logic        cmd_en;
    logic [20:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        init_calib;
    logic        busy;
    logic        protocol_error;

    int checks = 0;
    int errors = 0;

    logic [63:0] beats [4];
    logic [7:0]  masks [4];
    logic [63:0] exp   [4];

    burst_ram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .cmd_en         (cmd_en),
        .addr           (addr),
        .wr_data        (wr_data),
        .data_mask      (data_mask),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .init_calib     (init_calib),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        cmd_en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic write_burst(input logic [20:0] a, input int abort_at);
        cmd       = 1'b1;
        cmd_en    = 1'b1;
        addr      = a;
        wr_data   = beats[0];
        data_mask = masks[0];
        step();
        cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            wr_data   = beats[k];
            data_mask = masks[k];
            check($sformatf("wr busy a%0d b%0d", a, k), busy, 1);
            if (k == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            step();
        end
        check($sformatf("wr done a%0d", a), busy, 0);
    endtask

    // Cycle c counts from the accept edge; beats are due in cycles 3..6.
    task automatic read_burst(input logic [20:0] a, input int collide_at, input int reset_at);
        cmd    = 1'b0;
        cmd_en = 1'b1;
        addr   = a;
        step();
        for (int c = 1; c <= 7; c++) begin
            cmd_en    = (c == collide_at);
            cmd       = 1'b1;
            wr_data   = '0;
            data_mask = '0;
            check($sformatf("rd valid a%0d c%0d", a, c), rd_data_valid, (c >= 3 && c <= 6) ? 1 : 0);
            check($sformatf("rd data a%0d c%0d", a, c), rd_data, (c >= 3 && c <= 6) ? exp[c-3] : 64'h0);
            check($sformatf("rd busy a%0d c%0d", a, c), busy, (c <= 6) ? 1 : 0);
            if (c == reset_at) begin
                rst = 1'b1;
                step();
                rst    = 1'b0;
                cmd_en = 1'b0;
                return;
            end
            if (c < 7) step();
        end
        cmd_en = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd       = 1'b0;
        cmd_en    = 1'b0;
        addr      = '0;
        wr_data   = '0;
        data_mask = '0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state and calibration window; a write attempt during CALIB is ignored
        check("rst valid", rd_data_valid, 0);
        check("rst data", rd_data, 0);
        check("rst busy", busy, 0);
        check("rst perr", protocol_error, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("calib init c%0d", k), init_calib, 0);
            if (k == 3) begin
                check("calib cmd ignored", busy, 0);
                check("calib perr", protocol_error, PCHK);
            end
            cmd_en    = (k == 2);
            cmd       = 1'b1;
            addr      = 21'd300;
            wr_data   = 64'hBAD;
            data_mask = '0;
            step();
        end
        cmd_en = 1'b0;
        check("calib done init", init_calib, 1);
        check("calib done busy", busy, 0);

        // Write then read back at address 4
        beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        masks = '{8'h00, 8'h00, 8'h00, 8'h00};
        write_burst(21'd4, -1);
        exp = beats;
        read_burst(21'd4, -1, -1);

        // Byte masking: upper half written, lower half and masked beats untouched
        beats = '{64'h0, 64'h0, 64'h0, 64'h0};
        write_burst(21'd10, -1);
        beats = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
        masks = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
        write_burst(21'd10, -1);
        exp = '{64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 64'h0};
        read_burst(21'd10, -1, -1);

        // Wrap-around at the top of memory
        masks = '{8'h00, 8'h00, 8'h00, 8'h00};
        beats = '{64'hE0E0, 64'hF0F0, 64'h6060, 64'h7070};
        write_burst(21'd0, -1);
        beats = '{64'hA1A1, 64'hB2B2, 64'hC3C3, 64'hD4D4};
        write_burst(21'd1022, -1);
        exp = '{64'hA1A1, 64'hB2B2, 64'hC3C3, 64'hD4D4};
        read_burst({11'h5A5, 10'd1022}, -1, -1);
        exp = '{64'hC3C3, 64'hD4D4, 64'h6060, 64'h7070};
        read_burst(21'd0, -1, -1);

        // Collision during READ after a fresh reset clears the sticky flag
        do_reset();
        check("perr cleared", protocol_error, 0);
        repeat (8) step();
        check("recal init", init_calib, 1);
        exp = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        read_burst(21'd4, 4, -1);
        check("collision perr", protocol_error, PCHK);
        read_burst(21'd4, -1, -1);

        // Reset aborts a write after beat 1; earlier beats kept, later beats not written
        beats = '{64'h5050_0000, 64'h5151_0000, 64'h5252_0000, 64'h5353_0000};
        write_burst(21'd20, -1);
        beats = '{64'h9090_0000, 64'h9191_0000, 64'h9292_0000, 64'h9393_0000};
        write_burst(21'd20, 2);
        check("wr abort busy", busy, 0);
        check("wr abort init", init_calib, 0);
        repeat (8) step();
        exp = '{64'h9090_0000, 64'h9191_0000, 64'h5252_0000, 64'h5353_0000};
        read_burst(21'd20, -1, -1);

        // Reset mid-read after beat 1
        exp = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        read_burst(21'd4, -1, 4);
        check("rd abort valid", rd_data_valid, 0);
        check("rd abort data", rd_data, 0);
        check("rd abort init", init_calib, 0);
        check("rd abort busy", busy, 0);
        repeat (2) step();
        check("rd abort quiet", rd_data_valid, 0);
        repeat (6) step();
        check("rd abort recal", init_calib, 1);
        read_burst(21'd4, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
